mem_port_arbiter: RTL and testbench

- Shares the single block-wide RAM port between the instruction cache and the data cache.
- Each requester drives an enable/write/address/block request and waits for a one-cycle ready pulse.
- Grants exactly one requester at a time, with round-robin priority on ties, and registers all RAM-side outputs.
- Sits between both cache controllers and the RAM model.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide RAM port between the I-cache and D-cache.
// All RAM-side and requester-side outputs are registered; one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 3,
    parameter int BLOCK_WIDTH  = DATA_WIDTH << OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ic_en,
    input  logic                   ic_write,
    input  logic [ADDR_WIDTH-1:0]  ic_addr,
    input  logic [BLOCK_WIDTH-1:0] ic_wdata,
    output logic                   ic_ready,
    input  logic                   dc_en,
    input  logic                   dc_write,
    input  logic [ADDR_WIDTH-1:0]  dc_addr,
    input  logic [BLOCK_WIDTH-1:0] dc_wdata,
    output logic                   dc_ready,
    output logic [BLOCK_WIDTH-1:0] rdata,
    output logic                   ram_en,
    output logic                   ram_write,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [BLOCK_WIDTH-1:0] ram_wdata,
    input  logic                   ram_ready,
    input  logic [BLOCK_WIDTH-1:0] ram_rdata,
    output logic [1:0]             grant
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_last_dc;
    logic                   r_ic_ready;
    logic                   r_dc_ready;
    logic [BLOCK_WIDTH-1:0] r_rdata;
    logic                   r_ram_en;
    logic                   r_ram_write;
    logic [ADDR_WIDTH-1:0]  r_ram_addr;
    logic [BLOCK_WIDTH-1:0] r_ram_wdata;
    logic [1:0]             r_grant;
    logic                   w_pick_dc;

    // On a tie the requester that was not served last wins.
    assign w_pick_dc = dc_en && (!ic_en || !r_last_dc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last_dc   <= 1'b0;
            r_ic_ready  <= 1'b0;
            r_dc_ready  <= 1'b0;
            r_rdata     <= '0;
            r_ram_en    <= 1'b0;
            r_ram_write <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_grant     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ic_en || dc_en) begin
                        r_ram_en    <= 1'b1;
                        r_ram_write <= w_pick_dc ? dc_write : ic_write;
                        r_ram_addr  <= w_pick_dc ? dc_addr  : ic_addr;
                        r_ram_wdata <= w_pick_dc ? dc_wdata : ic_wdata;
                        r_grant     <= w_pick_dc ? 2'b10 : 2'b01;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ram_ready) begin
                        if (!r_ram_write) begin
                            r_rdata <= ram_rdata;
                        end
                        r_ram_en   <= 1'b0;
                        r_ic_ready <= r_grant[0];
                        r_dc_ready <= r_grant[1];
                        r_state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_ic_ready <= 1'b0;
                    r_dc_ready <= 1'b0;
                    r_last_dc  <= r_grant[1];
                    r_grant    <= 2'b00;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ic_ready  = r_ic_ready;
    assign dc_ready  = r_dc_ready;
    assign rdata     = r_rdata;
    assign ram_en    = r_ram_en;
    assign ram_write = r_ram_write;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign grant     = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, a vector table, hand-written corner sequences
// and randomized rounds checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int AW = 30;
    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ic_en = 1'b0, ic_write = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic [BW-1:0] ic_wdata = '0;
    logic          ic_ready;
    logic          dc_en = 1'b0, dc_write = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [BW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic [BW-1:0] rdata;
    logic          ram_en, ram_write;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_wdata;
    logic          ram_ready = 1'b0;
    logic [BW-1:0] ram_rdata = '0;
    logic [1:0]    grant;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: who was served last, and the last block read.
    bit            last_dc;
    logic [BW-1:0] exp_rdata;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_en(ic_en), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata), .ic_ready(ic_ready),
        .dc_en(dc_en), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_ready(dc_ready),
        .rdata(rdata),
        .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if ((ic_ready && dc_ready) || grant == 2'b11) begin
                n_fail++;
                $display("FAIL exclusive: ic_ready=%b dc_ready=%b grant=%b", ic_ready, dc_ready, grant);
            end
        end
    end

    // Round-robin rule: a lone requester wins; on a tie, the one not served last.
    function automatic logic [1:0] winner(input bit ie, input bit de);
        if (ie && de) return last_dc ? 2'b01 : 2'b10;
        if (de)       return 2'b10;
        if (ie)       return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [BW-1:0] rnd_blk();
        logic [BW-1:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        ic_en = 1'b0; dc_en = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_dc   = 1'b0;
        exp_rdata = '0;
    endtask

    // Called at the negedge of an idle cycle with the request(s) already driven.
    // Returns at the negedge of the idle cycle that follows the ready pulse.
    task automatic do_txn(input logic [1:0] g, input int lat, input logic [BW-1:0] rd, input bit drop);
        logic          w;
        logic [AW-1:0] a;
        logic [BW-1:0] wd;
        w  = g[1] ? dc_write : ic_write;
        a  = g[1] ? dc_addr  : ic_addr;
        wd = g[1] ? dc_wdata : ic_wdata;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("ram_en_busy", ram_en, 1'b1);
            chk("grant_busy", grant, g);
            chk("ram_addr", ram_addr, a);
            chk("ram_write", ram_write, w);
            chk("ram_wdata", ram_wdata, wd);
            chk("ready_busy", {ic_ready, dc_ready}, 2'b00);
            if (drop && i == 1) begin
                if (g[1]) dc_en = 1'b0; else ic_en = 1'b0;
            end
            ram_ready = (i == lat);
            ram_rdata = (i == lat) ? rd : ~rd;
        end
        @(negedge clk);
        ram_ready = 1'b0;
        if (!w) exp_rdata = rd;
        chk("ram_en_release", ram_en, 1'b0);
        chk("ic_ready", ic_ready, g[0]);
        chk("dc_ready", dc_ready, g[1]);
        chk("rdata", rdata, exp_rdata);
        last_dc = g[1];
        @(negedge clk);
        chk("ready_idle", {ic_ready, dc_ready}, 2'b00);
        chk("grant_idle", grant, 2'b00);
        chk("ram_en_idle", ram_en, 1'b0);
    endtask

    task automatic serve(input logic [1:0] e1, input logic [1:0] e2, input int lat, input logic [BW-1:0] rd);
        do_txn(e1, lat, rd, 1'b0);
        if (e1[1]) dc_en = 1'b0; else ic_en = 1'b0;
        if (e2 != 2'b00) begin
            do_txn(e2, lat, ~rd, 1'b0);
            if (e2[1]) dc_en = 1'b0; else ic_en = 1'b0;
        end
    endtask

    typedef struct {
        bit            ie, iw, de, dw;
        logic [AW-1:0] ia, da;
        int            lat;
        logic [1:0]    e1, e2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 0, 1, 0, 30'h40,  30'h80,  1, 2'b10, 2'b01};
        vecs[1] = '{0, 0, 1, 1, 30'h0,   30'h200, 2, 2'b10, 2'b00};
        vecs[2] = '{1, 0, 1, 0, 30'h44,  30'h84,  2, 2'b01, 2'b10};
        vecs[3] = '{1, 1, 0, 0, 30'h1F0, 30'h0,   1, 2'b01, 2'b00};
        vecs[4] = '{1, 1, 1, 0, 30'h48,  30'h88,  3, 2'b10, 2'b01};
        vecs[5] = '{0, 0, 1, 0, 30'h0,   30'h8C,  4, 2'b10, 2'b00};
        vecs[6] = '{1, 0, 0, 0, 30'h4C,  30'h0,   1, 2'b01, 2'b00};

        // Reset state
        @(negedge clk);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_ready", {ic_ready, dc_ready}, 2'b00);
        chk("rst_rdata", rdata, '0);
        chk("rst_ram_addr", ram_addr, '0);
        chk("rst_ram_write", ram_write, 1'b0);
        chk("rst_ram_wdata", ram_wdata, '0);
        rst = 1'b1; last_dc = 1'b0; exp_rdata = '0;

        // D-cache read from reset, RAM replies in the third busy cycle
        dc_en = 1'b1; dc_write = 1'b0; dc_addr = 30'h100;
        do_txn(2'b10, 3, {32{8'hA5}}, 1'b0);
        dc_en = 1'b0;

        // ram_ready outside BUSY is ignored
        ram_ready = 1'b1;
        repeat (2) @(negedge clk);
        ram_ready = 1'b0;
        chk("idle_ready_ignored", {ram_en, ic_ready, dc_ready, grant}, 5'b0);
        chk("idle_rdata_kept", rdata, exp_rdata);

        // Vector table, starting from reset
        do_reset();
        foreach (vecs[n]) begin
            ic_en = vecs[n].ie; ic_write = vecs[n].iw; ic_addr = vecs[n].ia;
            ic_wdata = {8{2'b00, vecs[n].ia}};
            dc_en = vecs[n].de; dc_write = vecs[n].dw; dc_addr = vecs[n].da;
            dc_wdata = ~{8{2'b00, vecs[n].da}};
            serve(vecs[n].e1, vecs[n].e2, vecs[n].lat, {8{2'b10, vecs[n].ia ^ vecs[n].da}});
        end

        // Writeback keeps rdata
        do_reset();
        dc_en = 1'b1; dc_write = 1'b0; dc_addr = 30'h20;
        do_txn(2'b10, 1, {32{8'h5A}}, 1'b0);
        dc_en = 1'b0;
        @(negedge clk);
        dc_en = 1'b1; dc_write = 1'b1; dc_addr = 30'h3FF8; dc_wdata = {8{32'h12345678}};
        do_txn(2'b10, 2, {32{8'hEE}}, 1'b0);
        dc_en = 1'b0; dc_write = 1'b0;

        // Both held continuously: grants alternate D, I, D, I
        do_reset();
        ic_en = 1'b1; ic_addr = 30'h11; dc_en = 1'b1; dc_addr = 30'h22;
        do_txn(2'b10, 1, rnd_blk(), 1'b0);
        do_txn(2'b01, 2, rnd_blk(), 1'b0);
        do_txn(2'b10, 1, rnd_blk(), 1'b0);
        do_txn(2'b01, 3, rnd_blk(), 1'b0);
        ic_en = 1'b0; dc_en = 1'b0;

        // Reset while BUSY aborts at once, then a fresh request is served
        @(negedge clk);
        ic_en = 1'b1; ic_addr = 30'h77;
        @(negedge clk);
        chk("pre_abort_ram_en", ram_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_ram_en", ram_en, 1'b0);
        chk("abort_grant", grant, 2'b00);
        chk("abort_ready", {ic_ready, dc_ready}, 2'b00);
        ic_en = 1'b0;
        @(negedge clk);
        rst = 1'b1; last_dc = 1'b0; exp_rdata = '0;
        chk("post_abort_ready", {ic_ready, dc_ready}, 2'b00);
        dc_en = 1'b1; dc_addr = 30'h99;
        do_txn(2'b10, 2, rnd_blk(), 1'b0);
        dc_en = 1'b0;

        // Granted requester drops en mid-BUSY; access still completes
        ic_en = 1'b1; ic_write = 1'b0; ic_addr = 30'h55;
        do_txn(2'b01, 4, rnd_blk(), 1'b1);
        repeat (2) @(negedge clk);
        chk("drop_no_regrant", {ram_en, grant}, 3'b000);

        // Randomized rounds against the round-robin model
        for (int r = 0; r < 40; r++) begin
            bit ie, de;
            logic [1:0] e1, e2;
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            if (!ie && !de) de = 1'b1;
            ic_write = 1'($urandom_range(0, 1)); ic_addr = AW'($urandom); ic_wdata = rnd_blk();
            dc_write = 1'($urandom_range(0, 1)); dc_addr = AW'($urandom); dc_wdata = rnd_blk();
            ic_en = ie; dc_en = de;
            e1 = winner(ie, de);
            e2 = (ie && de) ? ~e1 : 2'b00;
            serve(e1, e2, int'($urandom_range(1, 4)), rnd_blk());
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
